// File: rtl/adder_tile_pkg.sv
// Shared constants for the adder tile: operand width, FSM state codes and pin indices.
// Pure declarations; no timing or flow-control behaviour.
package adder_tile_pkg;

   localparam int ADDER_WIDTH = 8;
   localparam int STATE_W     = 2;

   typedef logic [STATE_W-1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_GOT_A = 2'd1;
   localparam state_t ST_CALC  = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   // Bit positions of the host control pins on uio_in
   localparam int STROBE_BIT = 0;
   localparam int CLR_BIT    = 1;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchroniser plus rising-edge pulse for one async host pin; the level appears SYNC_STAGES clocks late.
// The rise pulse lasts one enabled cycle; with ena low the chain freezes, so a pending edge stays pending.
module sync_edge_detect #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic ena,
   input  logic i_async,
   output logic o_level,
   output logic o_rise
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sync <= '0;
         r_prev <= 1'b0;
      end else if (ena) begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_prev <= r_sync[SYNC_STAGES-1];
      end
   end

   assign o_level = r_sync[SYNC_STAGES-1];
   assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/adder_operand_loader.sv
// Loads operand A then B on synchronised strobe edges and registers {carry,sum}=A+B one clock after B.
// A synchronised clr level overrides strobe; ena low freezes everything.
module adder_operand_loader
   import adder_tile_pkg::*;
#(
   parameter int WIDTH       = ADDER_WIDTH,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [WIDTH-1:0] data_in,
   input  logic             strobe,
   input  logic             clr,
   output logic [WIDTH-1:0] sum,
   output logic             carry,
   output logic             valid,
   output logic [1:0]       state,
   output logic             ack
);

   state_t           r_state;
   state_t           w_next_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_valid;
   logic             r_ack;
   logic [WIDTH:0]   w_add;
   logic             w_strobe_rise;
   logic             w_strobe_lvl_unused;
   logic             w_clr_lvl;
   logic             w_clr_rise_unused;
   logic             w_load_a;
   logic             w_load_b;
   logic             w_calc;

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_strobe_sync (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .i_async (strobe),
      .o_level (w_strobe_lvl_unused),
      .o_rise  (w_strobe_rise)
   );

   sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_clr_sync (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .i_async (clr),
      .o_level (w_clr_lvl),
      .o_rise  (w_clr_rise_unused)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else if (ena) begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      if (w_clr_lvl) begin
         w_next_state = ST_IDLE;
      end else begin
         case (r_state)
            ST_IDLE:  if (w_strobe_rise) w_next_state = ST_GOT_A;
            ST_GOT_A: if (w_strobe_rise) w_next_state = ST_CALC;
            ST_CALC:  w_next_state = ST_DONE;
            ST_DONE:  if (w_strobe_rise) w_next_state = ST_GOT_A;
            default:  w_next_state = ST_IDLE;
         endcase
      end
   end

   // Strobe edges landing in CALC fall through every term below and are dropped
   always_comb begin
      w_load_a = 1'b0;
      w_load_b = 1'b0;
      w_calc   = 1'b0;
      if (!w_clr_lvl) begin
         w_load_a = w_strobe_rise && (r_state == ST_IDLE || r_state == ST_DONE);
         w_load_b = w_strobe_rise && (r_state == ST_GOT_A);
         w_calc   = (r_state == ST_CALC);
      end
   end

   assign w_add = {1'b0, r_a} + {1'b0, r_b};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_valid <= 1'b0;
         r_ack   <= 1'b0;
      end else if (ena) begin
         if (w_clr_lvl) begin
            r_valid <= 1'b0;
         end
         if (w_load_a) begin
            r_a     <= data_in;
            r_valid <= 1'b0;
            r_ack   <= ~r_ack;
         end
         if (w_load_b) begin
            r_b   <= data_in;
            r_ack <= ~r_ack;
         end
         if (w_calc) begin
            {r_carry, r_sum} <= w_add;
            r_valid          <= 1'b1;
         end
      end
   end

   assign sum   = r_sum;
   assign carry = r_carry;
   assign valid = r_valid;
   assign state = r_state;
   assign ack   = r_ack;

endmodule

// File: tb/tb_adder_operand_loader.sv
// Directed bench for adder_operand_loader: a transaction-level model is checked every falling edge,
// and hand-computed literals pin the key results.
module tb_adder_operand_loader;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ena = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       strobe = 1'b0;
   logic       clr = 1'b0;
   logic [7:0] sum;
   logic       carry;
   logic       valid;
   logic [1:0] state;
   logic       ack;

   int n_cmp = 0;
   int n_err = 0;

   adder_operand_loader dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .data_in (data_in),
      .strobe  (strobe),
      .clr     (clr),
      .sum     (sum),
      .carry   (carry),
      .valid   (valid),
      .state   (state),
      .ack     (ack)
   );

   always #5 clk = ~clk;

   // Model: a pin change seen at enabled edge k is acted on at edge k+2, so an edge is
   // "sample two edges ago high, three edges ago low"; clr acts on its sample two edges ago.
   int  m_state;
   int  m_a, m_b, m_sum, m_total;
   bit  m_carry, m_valid, m_ack;
   bit  sq[3];
   bit  cq[3];
   bit  m_edge, m_clr;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_state = 0; m_a = 0; m_b = 0; m_sum = 0;
         m_carry = 0; m_valid = 0; m_ack = 0;
         sq = '{0, 0, 0};
         cq = '{0, 0, 0};
      end else if (ena) begin
         m_edge = sq[1] && !sq[2];
         m_clr  = cq[1];
         if (m_clr) begin
            m_state = 0;
            m_valid = 0;
         end else if ((m_state == 0 || m_state == 3) && m_edge) begin
            m_a = data_in; m_valid = 0; m_ack = !m_ack; m_state = 1;
         end else if (m_state == 1 && m_edge) begin
            m_b = data_in; m_ack = !m_ack; m_state = 2;
         end else if (m_state == 2) begin
            m_total = m_a + m_b;
            m_sum   = m_total % 256;
            m_carry = (m_total > 255);
            m_valid = 1;
            m_state = 3;
         end
         sq[2] = sq[1]; sq[1] = sq[0]; sq[0] = strobe;
         cq[2] = cq[1]; cq[1] = cq[0]; cq[0] = clr;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         n_cmp++;
         if (sum !== m_sum[7:0] || carry !== m_carry || valid !== m_valid ||
             state !== m_state[1:0] || ack !== m_ack) begin
            n_err++;
            $display("FAIL model_cycle t=%0t: got sum=%h carry=%b valid=%b state=%0d ack=%b, want sum=%h carry=%b valid=%b state=%0d ack=%b",
                     $time, sum, carry, valid, state, ack,
                     m_sum[7:0], m_carry, m_valid, m_state, m_ack);
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Raises strobe with operand d; st0/v0 are sampled just after the accepting edge, st1/v1 one clock later
   task automatic send_op(input logic [7:0] d, input int hold,
                          output logic [1:0] st0, output logic v0,
                          output logic [1:0] st1, output logic v1);
      @(negedge clk);
      data_in = d;
      strobe  = 1'b1;
      repeat (3) @(negedge clk);
      st0 = state; v0 = valid;
      @(negedge clk);
      st1 = state; v1 = valid;
      repeat (hold) @(negedge clk);
      strobe = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   logic [1:0] st0, st1;
   logic       v0, v1;
   logic       ack_before;

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_sum", sum, 8'h00);
      chk("reset_carry", carry, 0);
      chk("reset_valid", valid, 0);
      chk("reset_state", state, 0);
      chk("reset_ack", ack, 0);

      // 0x12 + 0x34
      send_op(8'h12, 0, st0, v0, st1, v1);
      chk("a_accept_state", st0, 1);
      chk("a_ack", ack, 1);
      send_op(8'h34, 0, st0, v0, st1, v1);
      chk("b_accept_state_calc", st0, 2);
      chk("b_accept_valid_low", v0, 0);
      chk("b_plus1_state_done", st1, 3);
      chk("b_plus1_valid_high", v1, 1);
      chk("sum_12_34", sum, 8'h46);
      chk("carry_12_34", carry, 0);
      chk("ack_twice", ack, 0);

      // Overflow cases
      send_op(8'hFF, 0, st0, v0, st1, v1);
      send_op(8'h01, 0, st0, v0, st1, v1);
      chk("sum_ff_01", sum, 8'h00);
      chk("carry_ff_01", carry, 1);
      send_op(8'h80, 0, st0, v0, st1, v1);
      send_op(8'h80, 0, st0, v0, st1, v1);
      chk("sum_80_80", sum, 8'h00);
      chk("carry_80_80", carry, 1);

      // Back-to-back pair straight out of DONE
      send_op(8'h05, 0, st0, v0, st1, v1);
      chk("b2b_state", st0, 1);
      chk("b2b_valid_cleared", v0, 0);
      send_op(8'h0A, 0, st0, v0, st1, v1);
      chk("sum_05_0a", sum, 8'h0F);
      chk("carry_05_0a", carry, 0);

      // Strobe held high for 20 clocks loads only once
      ack_before = ack;
      send_op(8'h21, 20, st0, v0, st1, v1);
      chk("held_state", state, 1);
      chk("held_ack_once", ack, !ack_before);

      // Strobe left high through CALC and DONE must not load again
      @(negedge clk);
      data_in = 8'h01;
      strobe  = 1'b1;
      repeat (3) @(negedge clk);
      chk("calc_entered", state, 2);
      ack_before = ack;
      repeat (6) @(negedge clk);
      chk("calc_strobe_no_load", state, 3);
      chk("calc_strobe_no_ack", ack, ack_before);
      chk("sum_21_01", sum, 8'h22);
      strobe = 1'b0;
      repeat (3) @(negedge clk);

      // clr in GOT_A
      send_op(8'h07, 0, st0, v0, st1, v1);
      chk("pre_clr_state", state, 1);
      ack_before = ack;
      clr = 1'b1;
      repeat (4) @(negedge clk);
      clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("clr_state_idle", state, 0);
      chk("clr_valid", valid, 0);
      chk("clr_ack_kept", ack, ack_before);
      chk("clr_sum_kept", sum, 8'h22);

      // Async reset from DONE, checked before the next clock edge
      send_op(8'h10, 0, st0, v0, st1, v1);
      send_op(8'h20, 0, st0, v0, st1, v1);
      chk("pre_rst_sum", sum, 8'h30);
      chk("pre_rst_state", state, 3);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      chk("arst_sum", sum, 8'h00);
      chk("arst_valid", valid, 0);
      chk("arst_state", state, 0);
      chk("arst_ack", ack, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // ena low during the B strobe: nothing moves until ena returns
      send_op(8'h03, 0, st0, v0, st1, v1);
      chk("ena_a_state", state, 1);
      @(negedge clk);
      ena     = 1'b0;
      data_in = 8'h04;
      strobe  = 1'b1;
      repeat (6) @(negedge clk);
      chk("ena_low_frozen", state, 1);
      ena = 1'b1;
      repeat (4) @(negedge clk);
      chk("ena_resume_state", state, 3);
      chk("sum_03_04", sum, 8'h07);
      strobe = 1'b0;
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
